// File: rtl/s_16bit_unfold_pkg.sv
// -----------------------------------------------------------------------------
// s_16bit_unfold_pkg
//   Shared types and widths for the folded-operand receiver.
//   - phase_e : byte phase within a four-byte frame (lo_a, fold_a, lo_b, fold_b)
//   - BYTE_W  : serial byte width
//   - WORD_W  : reconstructed operand width
// -----------------------------------------------------------------------------
package s_16bit_unfold_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        S_LOA = 2'd0,  // expecting low half of a
        S_AA  = 2'd1,  // expecting fold of a
        S_LOB = 2'd2,  // expecting low half of b
        S_BB  = 2'd3   // expecting fold of b (frame-completing byte)
    } phase_e;

endpackage

// File: rtl/s_16bit_unfold_outreg.sv
// -----------------------------------------------------------------------------
// s_16bit_unfold_outreg
//   Single-entry valid/ready output register for reconstructed word pairs.
//   Data only changes on a load, so the pair holds stable while the sink stalls.
//   A load in the same cycle as a drain keeps o_valid high with the new pair.
//
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     i_load         capture i_a/i_b this cycle (caller guarantees slot is free
//                    or draining)
//     i_a, i_b       pair to capture
//     i_ready        sink accepts the held pair
//     o_valid        a pair is held
//     o_a, o_b       held pair
// -----------------------------------------------------------------------------
module s_16bit_unfold_outreg
    import s_16bit_unfold_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_a,
    output logic [WORD_W-1:0] o_b
);

    logic              r_valid;
    logic [WORD_W-1:0] r_a;
    logic [WORD_W-1:0] r_b;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            if (i_load) begin
                r_valid <= 1'b1;
                r_a     <= i_a;
                r_b     <= i_b;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_a     = r_a;
    assign o_b     = r_b;

endmodule

// File: rtl/s_16bit_unfold.sv
// -----------------------------------------------------------------------------
// s_16bit_unfold
//   Byte-serial receiver that rebuilds two 16-bit operands from folded frames.
//   Frame byte order: lo_a, fold_a, lo_b, fold_b, where fold = hi ^ lo.
//   High halves are recovered as fold ^ lo and the pair is presented on a
//   single-entry valid/ready output.
//
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     in_valid/in_ready    byte handshake; in_sof marks lo_a of a frame
//     in_byte              serial byte
//     out_valid/out_ready  pair handshake
//     out_a, out_b         reconstructed operands
//     err_pulse            one-cycle pulse after a frame is aborted by in_sof
//     word_cnt             completed-frame counter (only when S16_UNFOLD_CNT_EN
//                          is defined)
//
//   Build option: define S16_UNFOLD_CNT_EN to add the word_cnt port/counter.
// -----------------------------------------------------------------------------
module s_16bit_unfold
    import s_16bit_unfold_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_a,
    output logic [WORD_W-1:0] out_b,
    output logic              err_pulse
`ifdef S16_UNFOLD_CNT_EN
    ,
    output logic [WORD_W-1:0] word_cnt
`endif
);

    phase_e            r_state;
    phase_e            w_state_nxt;
    logic [BYTE_W-1:0] r_lo_a;
    logic [BYTE_W-1:0] r_hi_a;
    logic [BYTE_W-1:0] r_lo_b;
    logic              r_err;
    logic              w_accept;
    logic              w_load;
    logic              w_abort;
    logic              w_out_valid;
    logic [WORD_W-1:0] w_pair_a;
    logic [WORD_W-1:0] w_pair_b;

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOA;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_abort     = 1'b0;
        // Only the completing byte can stall, and only while the old pair
        // is still waiting for the sink.
        in_ready    = !((r_state == S_BB) && w_out_valid && !out_ready);
        w_accept    = in_valid && in_ready;

        if (w_accept) begin
            if (in_sof) begin
                // sof restarts the frame from any phase; a partial frame is lost.
                w_state_nxt = S_AA;
                w_abort     = (r_state != S_LOA);
            end else begin
                unique case (r_state)
                    S_LOA: w_state_nxt = S_AA;
                    S_AA:  w_state_nxt = S_LOB;
                    S_LOB: w_state_nxt = S_BB;
                    S_BB: begin
                        w_state_nxt = S_LOA;
                        w_load      = 1'b1;
                    end
                    default: w_state_nxt = S_LOA;
                endcase
            end
        end
    end

    // NOTE: the byte registers are reset along with the control state so a
    // reset mid-frame leaves no stale halves behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo_a <= '0;
            r_hi_a <= '0;
            r_lo_b <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_abort;
            if (w_accept) begin
                if (in_sof || (r_state == S_LOA)) begin
                    r_lo_a <= in_byte;
                end else if (r_state == S_AA) begin
                    r_hi_a <= in_byte ^ r_lo_a;
                end else if (r_state == S_LOB) begin
                    r_lo_b <= in_byte;
                end
            end
        end
    end

    // hi_b is unfolded straight from the completing byte into the output slot.
    assign w_pair_a = {r_hi_a, r_lo_a};
    assign w_pair_b = {in_byte ^ r_lo_b, r_lo_b};

    s_16bit_unfold_outreg u_outreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_a     (w_pair_a),
        .i_b     (w_pair_b),
        .i_ready (out_ready),
        .o_valid (w_out_valid),
        .o_a     (out_a),
        .o_b     (out_b)
    );

    assign out_valid = w_out_valid;
    assign err_pulse = r_err;

`ifdef S16_UNFOLD_CNT_EN
    logic [WORD_W-1:0] r_word_cnt;

    // Counts completed frames only; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
        end else if (w_load) begin
            r_word_cnt <= r_word_cnt + 1'b1;
        end
    end

    assign word_cnt = r_word_cnt;
`endif

endmodule

// File: tb/tb_s_16bit_unfold.sv
// -----------------------------------------------------------------------------
// tb_s_16bit_unfold
//   Self-checking bench for s_16bit_unfold: directed frames (basic unfold,
//   output stall, sof abort, mid-frame reset) followed by random frames with
//   random sink back-pressure checked against a queue of expected word pairs.
// -----------------------------------------------------------------------------
module tb_s_16bit_unfold;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic        err_pulse;
`ifdef S16_UNFOLD_CNT_EN
    logic [15:0] word_cnt;
`endif

    int n_checks;
    int n_errors;
    int n_err_seen;
    int n_err_exp;
    int n_frames;
    bit mon_en;
    bit rand_ready;
    logic [31:0] exp_q[$];

    s_16bit_unfold dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .err_pulse (err_pulse)
`ifdef S16_UNFOLD_CNT_EN
        ,
        .word_cnt  (word_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1-2 time units
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        #1;
    endtask

    // Present one byte, wait (bounded) for in_ready, and let it be accepted.
    task automatic send(input logic sof, input logic [7:0] b);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_sof   = sof;
        in_byte  = b;
        #0;
        while (!in_ready && waited < 64) begin
            step();
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_byte  = 8'h00;
    endtask

    // Send a word as its low byte followed by its fold byte.
    task automatic send_word(input logic sof, input logic [15:0] w);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = w[7:0];
        hi = w[15:8];
        send(sof, lo);
        send(1'b0, hi ^ lo);
    endtask

    task automatic send_frame(input logic sof, input logic [15:0] a, input logic [15:0] b);
        send_word(sof, a);
        send_word(1'b0, b);
    endtask

    // Sink-side scoreboard: every handshaken pair must be the oldest expected one.
    always @(negedge clk) begin
        if (err_pulse === 1'b1) n_err_seen++;
        if (mon_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("rand_unexpected_pair", {out_a, out_b}, 32'hxxxxxxxx);
            end else begin
                check("rand_pair", {out_a, out_b}, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  lo;
        logic [7:0]  hi;
        int          nb;
        int          waited;
        logic        sof;

        n_checks   = 0;
        n_errors   = 0;
        n_err_seen = 0;
        n_err_exp  = 0;
        n_frames   = 0;
        mon_en     = 1'b0;
        rand_ready = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        in_byte    = 8'h00;
        out_ready  = 1'b1;

        // ---- reset state ----
        #2;
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_a",     {16'b0, out_a},     32'd0);
        check("rst_out_b",     {16'b0, out_b},     32'd0);
        check("rst_err",       {31'b0, err_pulse}, 32'd0);
`ifdef S16_UNFOLD_CNT_EN
        check("rst_word_cnt",  {16'b0, word_cnt},  32'd0);
`endif
        step();
        step();
        rst_n = 1'b1;
        step();

        // ---- basic frame: 34,26,CD,AB ----
        send(1'b1, 8'h34);
        send(1'b0, 8'h26);
        send(1'b0, 8'hCD);
        check("basic_no_early_valid", {31'b0, out_valid}, 32'd0);
        send(1'b0, 8'hAB);
        check("basic_valid", {31'b0, out_valid}, 32'd1);
        check("basic_out_a", {16'b0, out_a}, 32'h1234);
        check("basic_out_b", {16'b0, out_b}, 32'h66CD);
        step();
        check("basic_valid_one_cycle", {31'b0, out_valid}, 32'd0);
        n_frames++;

        // ---- back-to-back frames with sink stalled ----
        out_ready = 1'b0;
        send_frame(1'b1, 16'hBEEF, 16'h0102);
        check("stall_f1_valid", {31'b0, out_valid}, 32'd1);
        send_word(1'b1, 16'hCAFE);
        send(1'b0, 8'h88);
        check("stall_f1_hold_a", {16'b0, out_a}, 32'hBEEF);
        in_valid = 1'b1;
        in_byte  = 8'h77 ^ 8'h88;
        #1;
        check("stall_in_ready_low", {31'b0, in_ready}, 32'd0);
        step();
        step();
        check("stall_in_ready_still_low", {31'b0, in_ready}, 32'd0);
        check("stall_f1_hold_a2", {16'b0, out_a}, 32'hBEEF);
        check("stall_f1_hold_b2", {16'b0, out_b}, 32'h0102);
        out_ready = 1'b1;
        #1;
        check("stall_in_ready_release", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("stall_f2_valid", {31'b0, out_valid}, 32'd1);
        check("stall_f2_out_a", {16'b0, out_a}, 32'hCAFE);
        check("stall_f2_out_b", {16'b0, out_b}, 32'h7788);
        step();
        check("stall_drained", {31'b0, out_valid}, 32'd0);
        n_frames += 2;

        // ---- sof abort after two bytes ----
        send(1'b1, 8'h34);
        send(1'b0, 8'h26);
        check("abort_no_err_yet", {31'b0, err_pulse}, 32'd0);
        send(1'b1, 8'h00);
        check("abort_err_pulse", {31'b0, err_pulse}, 32'd1);
        n_err_exp++;
        send(1'b0, 8'hFF);
        check("abort_err_one_cycle", {31'b0, err_pulse}, 32'd0);
        send(1'b0, 8'h00);
        send(1'b0, 8'h0F);
        check("abort_valid", {31'b0, out_valid}, 32'd1);
        check("abort_out_a", {16'b0, out_a}, 32'hFF00);
        check("abort_out_b", {16'b0, out_b}, 32'h0F00);
        step();
        n_frames++;

        // ---- reset mid-frame with a pair held ----
        out_ready = 1'b0;
        send_frame(1'b1, 16'h5A5A, 16'hC3C3);
        send_word(1'b1, 16'h1357);
        send(1'b0, 8'h99);
        check("rstmid_held_before", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", {31'b0, out_valid}, 32'd0);
        check("rstmid_out_a", {16'b0, out_a}, 32'd0);
        check("rstmid_out_b", {16'b0, out_b}, 32'd0);
`ifdef S16_UNFOLD_CNT_EN
        check("rstmid_word_cnt", {16'b0, word_cnt}, 32'd0);
`endif
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        n_frames  = 0;
        step();
        send_frame(1'b0, 16'h2468, 16'h9ABC);
        check("rstmid_clean_valid", {31'b0, out_valid}, 32'd1);
        check("rstmid_clean_a", {16'b0, out_a}, 32'h2468);
        check("rstmid_clean_b", {16'b0, out_b}, 32'h9ABC);
        n_frames++;
        step();
        check("rstmid_clean_drained", {31'b0, out_valid}, 32'd0);

        // ---- random frames, random back-pressure, occasional aborts ----
        mon_en     = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            sof = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                nb = $urandom_range(1, 3);
                for (int k = 0; k < nb; k++) send(1'b0, 8'($urandom));
                sof = 1'b1;
                n_err_exp++;
            end
            a  = 16'($urandom);
            b  = 16'($urandom);
            send_word(sof, a);
            lo = b[7:0];
            hi = b[15:8];
            send(1'b0, lo);
            exp_q.push_back({a, b});
            send(1'b0, hi ^ lo);
            n_frames++;
        end

        // Drain whatever is still held and confirm nothing is left over.
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        waited     = 0;
        while (exp_q.size() != 0 && waited < 16) begin
            step();
            waited++;
        end
        step();
        check("rand_all_delivered", exp_q.size(), 32'd0);
        check("rand_final_idle", {31'b0, out_valid}, 32'd0);
        check("err_pulse_count", n_err_seen, n_err_exp);
`ifdef S16_UNFOLD_CNT_EN
        check("word_cnt_final", {16'b0, word_cnt}, n_frames);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/s_16bit_unfold.md
# s_16bit_unfold

Byte-serial receiver that rebuilds the two 16-bit operand words that were folded into 8-bit XOR digests upstream. Each frame carries four bytes in the order low half of a, fold of a, low half of b, fold of b. The block recovers each high half as fold XOR low, so a = {aa ^ a[7:0], a[7:0]}. It sits at the receive end of the folded-operand link and presents reconstructed word pairs on a valid/ready output port.

## Interface
- No parameters; all widths are fixed at 8 bits in and 16 bits out.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous assert, active-low reset.
- in_valid  in  1  in_byte is valid this cycle.
- in_sof  in  1  qualified by in_valid; marks the first byte (lo_a) of a frame.
- in_byte  in  8  serial byte.
- in_ready  out  1  block accepts in_byte this cycle.
- out_valid  out  1  out_a/out_b hold a reconstructed pair.
- out_ready  in  1  sink accepts the pair.
- out_a  out  16  reconstructed a.
- out_b  out  16  reconstructed b.
- err_pulse  out  1  one-cycle pulse when a frame is aborted.
- word_cnt  out  16  completed-frame counter; present only with S16_UNFOLD_CNT_EN.

## Operation
- A byte is accepted when in_valid && in_ready.
- Phase FSM: S_LOA -> S_AA -> S_LOB -> S_BB -> S_LOA. It advances one state per accepted byte.
- S_LOA stores lo_a.
- S_AA stores hi_a = in_byte ^ lo_a.
- S_LOB stores lo_b.
- S_BB computes hi_b = in_byte ^ lo_b and loads the output register {hi_a,lo_a}, {hi_b,lo_b}. It also sets out_valid.
- in_sof on an accepted byte forces that byte to be treated as lo_a, whatever the current state. The next state is S_AA.
- If in_sof arrives while the FSM is not in S_LOA, the partial frame is discarded. err_pulse goes high for one cycle in the cycle after acceptance.
- A byte accepted in S_LOA without in_sof is taken as lo_a. There is no error in this case, because sof is optional.
- Output register is a single entry. out_valid clears on out_valid && out_ready unless a new pair is loaded in the same cycle; in that case it stays 1 with the new data.
- in_ready = !(state == S_BB && out_valid && !out_ready). The block stalls only on the completing byte, and only while the old pair has not yet drained.
- out_a/out_b must hold stable while out_valid && !out_ready.

## Timing
- Reset values: state = S_LOA, out_valid = 0, out_a = out_b = 0, err_pulse = 0, word_cnt = 0, all internal byte registers 0.
- in_ready is combinational from state, out_valid and out_ready. It is 1 during reset release.
- Latency: out_valid rises in the cycle after the fourth byte is accepted.
- Sustained throughput: one frame every 4 cycles with out_ready tied high, with no bubbles.
- Simultaneous drain and load in S_BB: accepted. Old pair leaves, new pair loads, and out_valid stays 1.
- Reset mid-frame: the partial frame is lost and the output register is cleared immediately (asynchronously).

## Configuration
- S16_UNFOLD_CNT_EN defined:
  - word_cnt port exists.
  - It increments by 1 on each frame completion (load in S_BB) and wraps from 16'hFFFF to 0.
  - Aborted frames do not count.
- Undefined: no word_cnt port and no counter logic.

## Structure
- Package s_16bit_unfold_pkg holds:
  - The phase enum (S_LOA, S_AA, S_LOB, S_BB).
  - Localparams BYTE_W = 8 and WORD_W = 16.
- One sub-module, s_16bit_unfold_outreg: the single-entry valid/ready output register with the hold-stable rule.
- The unfold XOR stays inline.

## Test plan
- Frame with sof, bytes 34,26,CD,AB, out_ready=1 -> next cycle out_a=1234, out_b=66CD, out_valid=1 for 1 cycle.
- Two back-to-back frames with out_ready=0 -> in_ready=0 on the 8th byte until out_ready=1. First pair stays stable; second pair loads on the drain cycle.
- sof after 2 bytes (34,26), then full frame 00,FF,00,0F -> err_pulse once, out_a=FF00, out_b=0F00.
- rst_n low for 1 cycle after 3 bytes -> out_valid=0, outputs 0. The next 4 bytes form a clean frame.
- With S16_UNFOLD_CNT_EN: 65537 frames -> word_cnt=1. One aborted frame in the run does not change the count.
- Continuous 1000 random frames, random out_ready -> every out_a[15:8]^out_a[7:0] equals the sent fold byte, and the same holds for b. No pair is dropped or duplicated.
